// File: rtl/sum_splitter.sv
// sum_splitter: accepts a total on a valid/ready input handshake and emits it
// as a sequence of chunks on a valid/ready output handshake. Every chunk is
// CHUNK_MAX except the final one, which carries the remainder. A zero total
// produces a single zero chunk that is flagged as last.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   sum_in       total to split (SUM_W bits)
//   sum_valid    sum_in is valid
//   sum_ready    block can accept a new total (high only in IDLE)
//   chunk_out    current chunk value (CHUNK_W bits)
//   chunk_valid  chunk_out is valid (high only in EMIT)
//   chunk_ready  downstream accepts the current chunk
//   chunk_last   current chunk is the final chunk of the job
//   busy         a job is in progress (exposes the FSM state)
//   chunk_count  chunks accepted in the current or most recent job (saturating)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid output, once raised, holds its data stable until it is
// accepted. sum_ready and chunk_valid depend only on registered state, never
// on the partner's signal, so there is no combinational path input->output.

module sum_splitter #(
   parameter int SUM_W   = 5,
   parameter int CHUNK_W = 4,
   parameter int CNT_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SUM_W-1:0]   sum_in,
   input  logic               sum_valid,
   output logic               sum_ready,
   output logic [CHUNK_W-1:0] chunk_out,
   output logic               chunk_valid,
   input  logic               chunk_ready,
   output logic               chunk_last,
   output logic               busy,
   output logic [CNT_W-1:0]   chunk_count
);

   // Common width large enough to compare remaining against CHUNK_MAX
   // whichever of the two parameters is wider.
   localparam int WW = (SUM_W > CHUNK_W) ? SUM_W : CHUNK_W;
   localparam logic [CHUNK_W-1:0] CHUNK_MAX = '1;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t           state;
   logic [SUM_W-1:0] remaining;

   logic [WW-1:0] rem_w;
   logic [WW-1:0] max_w;
   logic [WW-1:0] min_w;
   logic [WW-1:0] next_w;
   logic          fits;
   logic          emit;
   logic          load;
   logic          accept;

   assign rem_w  = WW'(remaining);
   assign max_w  = WW'(CHUNK_MAX);
   assign fits   = (rem_w <= max_w);
   assign min_w  = fits ? rem_w : max_w;
   // min_w never exceeds remaining, so this cannot underflow.
   assign next_w = rem_w - min_w;

   assign emit   = (state == EMIT);
   assign load   = sum_valid && !emit;
   assign accept = chunk_ready && emit;

   // Outputs derived from registered state only.
   assign sum_ready   = !emit;
   assign chunk_valid = emit;
   assign busy        = emit;
   assign chunk_out   = emit ? min_w[CHUNK_W-1:0] : '0;
   assign chunk_last  = emit && fits;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         remaining   <= '0;
         chunk_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (load) begin
                  remaining   <= sum_in;
                  chunk_count <= '0;
                  state       <= EMIT;
               end
            end
            EMIT: begin
               // sum_valid is ignored here; nothing is queued.
               if (accept) begin
                  remaining <= next_w[SUM_W-1:0];
                  if (chunk_count != '1) begin
                     chunk_count <= chunk_count + CNT_W'(1);
                  end
                  if (fits) begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
